// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register-file hazard scoreboard.
// Register address width comes from the codebase REG_ADDR_BUS macro.
`default_nettype none

`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif

package reg_scoreboard_pkg;

  localparam int REG_NUM  = 32;
  localparam int REG_ZERO = 0;
  localparam int SB_CNT_W = 2;

  function automatic int sb_cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int SB_CNT_MAX = sb_cnt_max(SB_CNT_W);

  typedef logic [`REG_ADDR_BUS] reg_addr_t;

endpackage

`default_nettype wire

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter: one pending-write counter per GPR, saturating at both ends,
// with a synchronous clear used for pipeline flush.
`default_nettype none

module sb_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W,
  parameter int MAX   = SB_CNT_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

  // Simultaneous inc and dec cancel out and leave the count untouched.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

`ifndef SYNTHESIS
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(dec && !inc && !clr && cnt == '0))
    else $error("sb_counter: writeback retired with no pending write");
`endif

endmodule

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: ID-stage hazard scheduler tracking in-flight GPR writes.
// Optional SCOREBOARD_STAT_EN adds stall_cycles / raw_stall_cycles counters.
`default_nettype none

module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int REG_NUM = reg_scoreboard_pkg::REG_NUM,
  parameter int ADDR_W  = $bits(reg_addr_t),
  parameter int CNT_W   = SB_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic               reg_read_en_1,
  input  logic [ADDR_W-1:0]  reg_addr_1,
  input  logic               reg_read_en_2,
  input  logic [ADDR_W-1:0]  reg_addr_2,
  input  logic               reg_write_en,
  input  logic [ADDR_W-1:0]  reg_write_addr,
  input  logic               wb_en,
  input  logic [ADDR_W-1:0]  wb_addr,
  output logic [REG_NUM-1:0] busy_mask,
  output logic               stall
`ifdef SCOREBOARD_STAT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        raw_stall_cycles
`endif
);

  localparam int                MAX       = sb_cnt_max(CNT_W);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(REG_ZERO);

  logic [REG_NUM-1:0] busy;
  logic [REG_NUM-1:0] full;
  logic               raw;
  logic               waw_full;
  logic               fire;
  logic               inc_en;
  logic               dec_en;

  assign busy[0] = 1'b0;
  assign full[0] = 1'b0;

  // Flush clears every counter and masks the writeback of that cycle.
  assign inc_en = fire && reg_write_en && (reg_write_addr != ADDR_ZERO);
  assign dec_en = wb_en && !flush && (wb_addr != ADDR_ZERO);

  for (genvar i = 1; i < REG_NUM; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_i;

    sb_counter #(
      .CNT_W (CNT_W),
      .MAX   (MAX)
    ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (flush),
      .inc  (inc_en && (reg_write_addr == ADDR_W'(i))),
      .dec  (dec_en && (wb_addr == ADDR_W'(i))),
      .cnt  (cnt_i),
      .busy (busy[i])
    );

    assign full[i] = (cnt_i == CNT_W'(MAX));
  end

  // Hazards look only at registered counters, so a writeback frees issue next cycle.
  assign raw = (reg_read_en_1 && (reg_addr_1 != ADDR_ZERO) && busy[reg_addr_1]) ||
               (reg_read_en_2 && (reg_addr_2 != ADDR_ZERO) && busy[reg_addr_2]);
  assign waw_full = reg_write_en && (reg_write_addr != ADDR_ZERO) && full[reg_write_addr];

  assign issue_ready = !(raw || waw_full);
  assign stall       = issue_valid && !issue_ready;
  assign fire        = issue_valid && issue_ready && !flush;
  assign busy_mask   = busy;

`ifdef SCOREBOARD_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles     <= '0;
      raw_stall_cycles <= '0;
    end else begin
      if (stall)        stall_cycles     <= stall_cycles + 32'd1;
      if (stall && raw) raw_stall_cycles <= raw_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard using expected/observed queues.
`default_nettype none

module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic        reg_read_en_1;
  logic [4:0]  reg_addr_1;
  logic        reg_read_en_2;
  logic [4:0]  reg_addr_2;
  logic        reg_write_en;
  logic [4:0]  reg_write_addr;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] busy_mask;
  logic        stall;
`ifdef SCOREBOARD_STAT_EN
  logic [31:0] stall_cycles;
  logic [31:0] raw_stall_cycles;
`endif

  reg_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .reg_read_en_1  (reg_read_en_1),
    .reg_addr_1     (reg_addr_1),
    .reg_read_en_2  (reg_read_en_2),
    .reg_addr_2     (reg_addr_2),
    .reg_write_en   (reg_write_en),
    .reg_write_addr (reg_write_addr),
    .wb_en          (wb_en),
    .wb_addr        (wb_addr),
    .busy_mask      (busy_mask),
    .stall          (stall)
`ifdef SCOREBOARD_STAT_EN
    ,
    .stall_cycles     (stall_cycles),
    .raw_stall_cycles (raw_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] mask;
    logic        ready;
    logic        stl;
  } snap_t;

  snap_t exp_q[$];
  snap_t obs_q[$];
  int    vectors = 0;
  int    errors  = 0;

  localparam logic [31:0] B2  = 32'd1 << 2;
  localparam logic [31:0] B3  = 32'd1 << 3;
  localparam logic [31:0] B4  = 32'd1 << 4;
  localparam logic [31:0] B5  = 32'd1 << 5;
  localparam logic [31:0] B6  = 32'd1 << 6;
  localparam logic [31:0] B7  = 32'd1 << 7;
  localparam logic [31:0] B9  = 32'd1 << 9;
  localparam logic [31:0] B10 = 32'd1 << 10;
  localparam logic [31:0] B11 = 32'd1 << 11;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic re1, input logic [4:0] a1,
                       input logic re2, input logic [4:0] a2,
                       input logic we, input logic [4:0] wa,
                       input logic wbe, input logic [4:0] wba, input logic fl);
    issue_valid    = iv;
    reg_read_en_1  = re1;
    reg_addr_1     = a1;
    reg_read_en_2  = re2;
    reg_addr_2     = a2;
    reg_write_en   = we;
    reg_write_addr = wa;
    wb_en          = wbe;
    wb_addr        = wba;
    flush          = fl;
  endtask

  task automatic idle;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Pushes the expected snapshot and the DUT's present outputs.
  task automatic observe(input string nm, input logic [31:0] m, input logic r, input logic s);
    #1;
    exp_q.push_back('{nm, m, r, s});
    obs_q.push_back('{nm, busy_mask, issue_ready, stall});
  endtask

  task automatic test_reset;
    snap_t e, o;
    rst = 1'b1;
    drive(1, 1, 5, 1, 6, 1, 7, 0, 0, 0);
    tick;
    tick;
    rst = 1'b0;
    idle;
    observe("reset_idle", 32'd0, 1'b1, 1'b0);
    drive(1, 1, 5, 1, 6, 0, 0, 0, 0, 0);
    observe("reset_read", 32'd0, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if ({o.mask, o.ready, o.stl} !== {e.mask, e.ready, e.stl}) begin
        errors++;
        $display("FAIL %s: got mask=%h ready=%b stall=%b, expected mask=%h ready=%b stall=%b",
                 e.name, o.mask, o.ready, o.stl, e.mask, e.ready, e.stl);
      end
    end
  endtask

  task automatic test_raw;
    snap_t e, o;
    tick; drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    observe("raw_write_r5", 32'd0, 1'b1, 1'b0);
    tick; drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    observe("raw_read_busy", B5, 1'b0, 1'b1);
    tick;
    observe("raw_hold", B5, 1'b0, 1'b1);
    drive(1, 1, 5, 0, 0, 0, 0, 1, 5, 0);
    observe("raw_wb_no_bypass", B5, 1'b0, 1'b1);
    tick; drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    observe("raw_released", 32'd0, 1'b1, 1'b0);
    tick; drive(1, 0, 0, 0, 0, 1, 11, 0, 0, 0);
    observe("raw_write_r11", 32'd0, 1'b1, 1'b0);
    tick; drive(1, 1, 12, 1, 11, 0, 0, 0, 0, 0);
    observe("raw_src2_busy", B11, 1'b0, 1'b1);
    drive(0, 1, 12, 1, 11, 0, 0, 1, 11, 0);
    observe("raw_src2_novalid", B11, 1'b0, 1'b0);
    tick; idle;
    observe("raw_src2_clear", 32'd0, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if ({o.mask, o.ready, o.stl} !== {e.mask, e.ready, e.stl}) begin
        errors++;
        $display("FAIL %s: got mask=%h ready=%b stall=%b, expected mask=%h ready=%b stall=%b",
                 e.name, o.mask, o.ready, o.stl, e.mask, e.ready, e.stl);
      end
    end
  endtask

  task automatic test_simultaneous;
    snap_t e, o;
    tick; drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    observe("sim_w7", 32'd0, 1'b1, 1'b0);
    tick; drive(1, 0, 0, 0, 0, 1, 7, 1, 7, 0);
    observe("sim_w7_wb7", B7, 1'b1, 1'b0);
    tick; drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
    observe("sim_r7_still_one", B7, 1'b1, 1'b0);
    tick; drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    observe("sim_r7_drained", 32'd0, 1'b1, 1'b0);
    tick; drive(1, 0, 0, 0, 0, 1, 3, 1, 9, 0);
    observe("sim_w3_wb9", B9, 1'b1, 1'b0);
    tick; drive(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    observe("sim_r3_set_r9_clear", B3, 1'b1, 1'b0);
    tick; idle;
    observe("sim_clean", 32'd0, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if ({o.mask, o.ready, o.stl} !== {e.mask, e.ready, e.stl}) begin
        errors++;
        $display("FAIL %s: got mask=%h ready=%b stall=%b, expected mask=%h ready=%b stall=%b",
                 e.name, o.mask, o.ready, o.stl, e.mask, e.ready, e.stl);
      end
    end
  endtask

  task automatic test_saturation;
    snap_t e, o;
    for (int k = 0; k < 3; k++) begin
      tick; drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
      observe("sat_write", (k == 0) ? 32'd0 : B2, 1'b1, 1'b0);
    end
    tick; drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    observe("sat_full", B2, 1'b0, 1'b1);
    tick;
    observe("sat_hold", B2, 1'b0, 1'b1);
    drive(1, 0, 0, 0, 0, 1, 2, 1, 2, 0);
    observe("sat_wb_no_bypass", B2, 1'b0, 1'b1);
    tick; drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    observe("sat_released", B2, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick; drive(0, 0, 0, 0, 0, 1, 2, 1, 2, 0);
      observe("sat_drain", B2, (k == 0) ? 1'b0 : 1'b1, 1'b0);
    end
    tick; idle;
    observe("sat_empty", 32'd0, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if ({o.mask, o.ready, o.stl} !== {e.mask, e.ready, e.stl}) begin
        errors++;
        $display("FAIL %s: got mask=%h ready=%b stall=%b, expected mask=%h ready=%b stall=%b",
                 e.name, o.mask, o.ready, o.stl, e.mask, e.ready, e.stl);
      end
    end
  endtask

  task automatic test_reg_zero;
    snap_t e, o;
    for (int k = 0; k < 5; k++) begin
      tick; drive(1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
      observe("zero_rw", 32'd0, 1'b1, 1'b0);
    end
    tick; drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    observe("zero_wb", 32'd0, 1'b1, 1'b0);
    tick; idle;
    observe("zero_after", 32'd0, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if ({o.mask, o.ready, o.stl} !== {e.mask, e.ready, e.stl}) begin
        errors++;
        $display("FAIL %s: got mask=%h ready=%b stall=%b, expected mask=%h ready=%b stall=%b",
                 e.name, o.mask, o.ready, o.stl, e.mask, e.ready, e.stl);
      end
    end
  endtask

  task automatic test_flush_reset;
    snap_t e, o;
    tick; drive(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
    observe("fl_w4", 32'd0, 1'b1, 1'b0);
    tick; drive(1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
    observe("fl_w6", B4, 1'b1, 1'b0);
    tick; drive(1, 0, 0, 0, 0, 1, 8, 1, 4, 1);
    observe("fl_flush_cycle", B4 | B6, 1'b1, 1'b0);
    tick; drive(1, 1, 8, 1, 4, 0, 0, 0, 0, 0);
    observe("fl_cleared", 32'd0, 1'b1, 1'b0);
    tick; drive(1, 0, 0, 0, 0, 1, 10, 0, 0, 0);
    observe("rst_w10", 32'd0, 1'b1, 1'b0);
    tick; drive(1, 0, 0, 0, 0, 1, 12, 1, 10, 1);
    rst = 1'b1;
    observe("rst_cycle", B10, 1'b1, 1'b0);
    tick; rst = 1'b0; drive(1, 1, 12, 1, 10, 0, 0, 0, 0, 0);
    observe("rst_cleared", 32'd0, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if ({o.mask, o.ready, o.stl} !== {e.mask, e.ready, e.stl}) begin
        errors++;
        $display("FAIL %s: got mask=%h ready=%b stall=%b, expected mask=%h ready=%b stall=%b",
                 e.name, o.mask, o.ready, o.stl, e.mask, e.ready, e.stl);
      end
    end
  endtask

`ifdef SCOREBOARD_STAT_EN
  task automatic test_stats;
    tick; idle; rst = 1'b1;
    tick; rst = 1'b0;
    vectors++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL stat_reset: got stall_cycles=%0d, expected 0", stall_cycles);
    end
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    tick; drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) tick;
    vectors++;
    if (stall_cycles !== 32'd5 || raw_stall_cycles !== 32'd5) begin
      errors++;
      $display("FAIL stat_count: got stall=%0d raw=%0d, expected 5 and 5",
               stall_cycles, raw_stall_cycles);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick; idle;
    tick;
    vectors++;
    if (stall_cycles !== 32'd5 || raw_stall_cycles !== 32'd5 || busy_mask !== 32'd0) begin
      errors++;
      $display("FAIL stat_flush: got stall=%0d raw=%0d mask=%h, expected 5 5 0",
               stall_cycles, raw_stall_cycles, busy_mask);
    end
    rst = 1'b1;
    tick; rst = 1'b0;
    vectors++;
    if (stall_cycles !== 32'd0 || raw_stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL stat_rst: got stall=%0d raw=%0d, expected 0 0",
               stall_cycles, raw_stall_cycles);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle;
    test_reset;
    test_raw;
    test_simultaneous;
    test_saturation;
    test_reg_zero;
    test_flush_reset;
`ifdef SCOREBOARD_STAT_EN
    test_stats;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
